// File: rtl/alu_sched.sv
// alu_sched: round-robin sequencer for the shared 16-bit ALU with response channel and flag register
module alu_sched #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_op,
  input  logic [15:0] req0_opa,
  input  logic [15:0] req0_opb,
  input  logic [15:0] req0_iv16,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_op,
  input  logic [15:0] req1_opa,
  input  logic [15:0] req1_opb,
  input  logic [15:0] req1_iv16,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic [15:0] rsp_result2,
  output logic        rsp_err,
  output logic        flag_c,
  output logic        flag_v,
  output logic        flag_z,
  output logic        flag_n,
  output logic [15:0] alu_opa,
  output logic [15:0] alu_opb,
  output logic [15:0] alu_iv16,
  output logic [7:0]  alu_ctl,
  input  logic [15:0] alu_result,
  input  logic [15:0] alu_result2,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        alu_z,
  input  logic        alu_n,
  output logic        busy
);
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_MUL = 8'h14;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e      state_q, state_d;
  logic        ptr_q, id_q, err_q;
  logic [7:0]  op_q;
  logic [15:0] opa_q, opb_q, iv_q, res_q, res2_q;
  logic [2:0]  cnt_q;
  logic [3:0]  flags_q;
  logic        gnt, acc, sel_legal, last;
  logic [7:0]  sel_op;
  // tie goes to the requester not granted last; a lone request always wins
  assign gnt        = (req0_valid && req1_valid) ? ~ptr_q : req1_valid;
  assign req0_ready = (state_q == IDLE) && req0_valid && !gnt;
  assign req1_ready = (state_q == IDLE) && req1_valid && gnt;
  assign acc        = req0_ready || req1_ready;
  assign sel_op     = gnt ? req1_op : req0_op;
  assign sel_legal  = sel_op inside {8'h12, 8'h13, 8'h14, 8'h0A, 8'h0C, 8'h15};
  assign last       = (op_q != OP_MUL) || (cnt_q == 3'(MUL_CYCLES - 1));
  assign alu_ctl    = (state_q == EXEC) ? op_q : OP_NOP;
  assign alu_opa    = opa_q;
  assign alu_opb    = opb_q;
  assign alu_iv16   = iv_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_result2 = res2_q;
  assign rsp_err    = err_q;
  assign {flag_c, flag_v, flag_z, flag_n} = flags_q;
  assign busy       = (state_q != IDLE);
  // next state: NOP/illegal skip straight to the response
  always_comb begin
    state_d = state_q;
    if (acc) state_d = sel_legal ? EXEC : RESP;
    else if (state_q == EXEC && last) state_d = RESP;
    else if (state_q == RESP && rsp_ready) state_d = IDLE;
  end
  // state, request capture, result capture and flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= OP_NOP;
      opa_q   <= '0;
      opb_q   <= '0;
      iv_q    <= '0;
      res_q   <= '0;
      res2_q  <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        ptr_q  <= gnt;
        id_q   <= gnt;
        op_q   <= sel_op;
        cnt_q  <= '0;
        res_q  <= '0;
        res2_q <= '0;
        err_q  <= !sel_legal && (sel_op != OP_NOP);
        if (sel_legal) begin
          opa_q <= gnt ? req1_opa : req0_opa;
          opb_q <= gnt ? req1_opb : req0_opb;
          iv_q  <= gnt ? req1_iv16 : req0_iv16;
        end
      end
      if (state_q == EXEC) begin
        cnt_q <= cnt_q + 3'd1;
        if (last) begin
          res_q   <= alu_result;
          res2_q  <= (op_q == OP_MUL) ? alu_result2 : 16'h0000;
          flags_q <= {alu_c, alu_v, alu_z, alu_n};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: randomized transaction-level check of alu_sched against a reference model
module tb_alu_sched;
  localparam int MC = 2;
  logic        clk = 0, rst_n = 0;
  logic        req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy;
  logic [7:0]  req0_op = 0, req1_op = 0, alu_ctl;
  logic [15:0] req0_opa = 0, req0_opb = 0, req0_iv16 = 0;
  logic [15:0] req1_opa = 0, req1_opb = 0, req1_iv16 = 0;
  logic [15:0] rsp_result, rsp_result2, alu_opa, alu_opb, alu_iv16, alu_result, alu_result2;
  logic        flag_c, flag_v, flag_z, flag_n, alu_c, alu_v, alu_z, alu_n;
  int          checks = 0, failures = 0;
  int          last_g = 1;
  logic [3:0]  mflags = 0;
  logic [15:0] la = 0, lb = 0, li = 0;
  logic [7:0]  op_tab [8] = '{8'h12, 8'h13, 8'h14, 8'h0A, 8'h0C, 8'h15, 8'h00, 8'h55};

  alu_sched #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_opa(req0_opa), .req0_opb(req0_opb), .req0_iv16(req0_iv16),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_opa(req1_opa), .req1_opb(req1_opb), .req1_iv16(req1_iv16),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_result2(rsp_result2), .rsp_err(rsp_err),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_iv16(alu_iv16), .alu_ctl(alu_ctl),
    .alu_result(alu_result), .alu_result2(alu_result2),
    .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n), .busy(busy)
  );

  always #5 clk = ~clk;

  // returns {c,v,z,n, high word, low word}
  function automatic logic [35:0] alu_f(input logic [7:0] op, input logic [15:0] a, b, iv);
    logic [16:0] s;
    logic [31:0] p;
    logic [15:0] r, r2;
    logic c, v;
    s = '0; p = '0; r2 = '0; c = 0; v = 0;
    case (op)
      8'h12: begin s = {1'b0, a} + b; v = (a[15] == b[15]) && (s[15] != a[15]); end
      8'h15: begin s = {1'b0, a} + iv; v = (a[15] == iv[15]) && (s[15] != a[15]); end
      8'h13: begin s = {1'b0, a} - b; v = (a[15] != b[15]) && (s[15] != a[15]); end
      8'h14: begin p = a * b; s = {1'b0, p[15:0]}; r2 = p[31:16]; end
      default: s = '0;
    endcase
    c = s[16];
    r = s[15:0];
    if (op == 8'h0A) return {4'b0, 16'h0, a | iv};
    if (op == 8'h0C) return {4'b0, 16'h0, a & iv};
    if (!(op inside {8'h12, 8'h13, 8'h14, 8'h15})) return '0;
    return {c, v, r == 0, r[15], r2, r};
  endfunction

  // ALU stub: drives garbage on the high word for non-MUL ops
  logic [35:0] alu_out;
  assign alu_out = alu_f(alu_ctl, alu_opa, alu_opb, alu_iv16);
  assign {alu_c, alu_v, alu_z, alu_n} = alu_out[35:32];
  assign alu_result  = alu_out[15:0];
  assign alu_result2 = (alu_ctl == 8'h14) ? alu_out[31:16] : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one full transaction; entered and left at a negedge
  task automatic txn(input logic v0, v1, input logic [7:0] o0, o1,
                     input logic [15:0] a0, b0, i0, a1, b1, i1, input int d);
    int w, n, lat;
    logic [7:0] op;
    logic [15:0] a, b, i;
    logic [35:0] r;
    logic legal;
    w = (v0 && v1) ? 1 - last_g : (v0 ? 0 : 1);
    last_g = w;
    {req0_valid, req0_op, req0_opa, req0_opb, req0_iv16} = {v0, o0, a0, b0, i0};
    {req1_valid, req1_op, req1_opa, req1_opb, req1_iv16} = {v1, o1, a1, b1, i1};
    {op, a, b, i} = (w == 0) ? {o0, a0, b0, i0} : {o1, a1, b1, i1};
    legal = op inside {8'h12, 8'h13, 8'h14, 8'h0A, 8'h0C, 8'h15};
    lat = !legal ? 0 : (op == 8'h14 ? MC : 1);
    r = alu_f(op, a, b, i);
    #1;
    chk("grant", {req0_ready, req1_ready}, (w == 0) ? 2'b10 : 2'b01);
    chk("idle_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    if (w == 0) req0_valid = 0; else req1_valid = 0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      chk("exec_rdy", {req0_ready, req1_ready}, 0);
      chk("exec_ctl", alu_ctl, legal ? op : 8'h00);
      chk("exec_opnd", {alu_opa, alu_opb}, {a, b});
      chk("exec_iv", alu_iv16, i);
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    if (legal) begin
      mflags = r[35:32];
      {la, lb, li} = {a, b, i};
    end
    for (int k = 0; k <= d; k++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id_err", {rsp_id, rsp_err}, {w[0], !legal && op != 8'h00});
      chk("rsp_res", {rsp_result2, rsp_result}, legal ? {(op == 8'h14) ? r[31:16] : 16'h0, r[15:0]} : 32'h0);
      chk("flags", {flag_c, flag_v, flag_z, flag_n}, mflags);
      chk("resp_alu", {alu_ctl, alu_opa}, {8'h00, la});
      chk("resp_hold", {alu_opb, alu_iv16}, {lb, li});
      chk("resp_rdy", {req0_ready, req1_ready, busy}, 3'b001);
      if (k == d) rsp_ready = 1;
      @(negedge clk);
    end
    rsp_ready = 0;
    chk("post_hs", {rsp_valid, busy}, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, flag_c, flag_v, flag_z, flag_n, busy, alu_ctl}, 0);
    chk({tag, "_rsp"}, {rsp_result, rsp_result2}, 0);
    chk({tag, "_alu"}, {alu_opa, alu_opb}, 0);
    chk({tag, "_iv"}, alu_iv16, 0);
  endtask

  initial begin
    #12;
    chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1;
    txn(1, 0, 8'h12, 0, 16'h7FFF, 16'h0001, 0, 0, 0, 0, 0);
    txn(0, 1, 0, 8'h14, 0, 0, 0, 16'h0100, 16'h0100, 0, 0);
    for (int k = 0; k < 4; k++)
      txn(1, 1, 8'h15, 8'h15, 16'(k), 0, 16'h10, 16'(k + 8), 0, 16'h20, 0);
    txn(1, 0, 8'h12, 0, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 0);
    txn(0, 1, 0, 8'h55, 0, 0, 0, 16'h1234, 16'h5678, 16'h9ABC, 1);
    txn(1, 0, 8'h00, 0, 16'h4321, 16'h1111, 16'h2222, 0, 0, 0, 0);
    txn(1, 1, 8'h13, 8'h12, 16'd5, 16'd5, 0, 16'd1, 16'd2, 0, 4);
    for (int t = 0; t < 60; t++) begin
      logic v0, v1;
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1;
      txn(v0, v1, op_tab[$urandom_range(7)], op_tab[$urandom_range(7)],
          16'($urandom), ($urandom % 4 == 0) ? 16'h0 : 16'($urandom), 16'($urandom),
          16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(3));
    end
    req0_valid = 0;
    req1_valid = 0;
    {req1_valid, req1_op, req1_opa, req1_opb} = {1'b1, 8'h14, 16'h0100, 16'h0100};
    @(posedge clk);
    @(negedge clk);
    req1_valid = 0;
    chk("mul_exec", {busy, alu_ctl}, {1'b1, 8'h14});
    #2 rst_n = 0;
    #1;
    chk_reset_outs("async_rst");
    @(negedge clk);
    rst_n = 1;
    last_g = 1;
    mflags = 0;
    {la, lb, li} = '0;
    for (int k = 0; k < 4; k++) begin
      chk("no_lost_rsp", {rsp_valid, busy}, 0);
      @(negedge clk);
    end
    txn(1, 1, 8'h12, 8'h13, 16'h0003, 16'h0004, 0, 16'h0009, 16'h0001, 0, 0);
    req0_valid = 0;
    req1_valid = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
